// File: rtl/write_controller_if.sv
// -----------------------------------------------------------------------------
// write_controller_if
//   Packet type shared by the UART packet link, and the bus bundle that
//   connects the register-write command handler to its environment.
//
//   Handshake: a byte on a UART_PACKET stream is transferred on a rising edge
//   of ipClk only when its Valid field is 1 and the sink is ready. The RX
//   stream has no back-pressure, so its sink is always ready. The TX stream
//   is ready when ipTxReady=1. While Valid=1 and ready=0, the source holds
//   every field of the stream stable.
//
//   Signals:
//     ipRxStream   RX packet bytes into the controller
//     ipTxReady    TX sink can accept the byte presented this cycle
//     opTxStream   ack packet bytes out of the controller
//     opWrAddress  register address for the write strobe
//     opWrData     register write data, 8*DATA_LENGTH bits
//     opWrEnable   one-cycle write strobe
//     opError      one-cycle pulse when a malformed packet is dropped
//   Modports:
//     slave   the controller side
//     master  the environment side (packetiser, TX sink, register file)
// -----------------------------------------------------------------------------
package write_controller_pkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

interface write_controller_if #(
    parameter int DATA_LENGTH = 4
);
    import write_controller_pkg::*;

    UART_PACKET                   ipRxStream;
    logic                         ipTxReady;
    UART_PACKET                   opTxStream;
    logic [7:0]                   opWrAddress;
    logic [8*DATA_LENGTH-1:0]     opWrData;
    logic                         opWrEnable;
    logic                         opError;

    modport slave (
        input  ipRxStream,
        input  ipTxReady,
        output opTxStream,
        output opWrAddress,
        output opWrData,
        output opWrEnable,
        output opError
    );

    modport master (
        output ipRxStream,
        output ipTxReady,
        input  opTxStream,
        input  opWrAddress,
        input  opWrData,
        input  opWrEnable,
        input  opError
    );
endinterface

// File: rtl/write_controller.sv
// -----------------------------------------------------------------------------
// write_controller
//   Receive-side handler for register writes over the UART packet link.
//   Accepts a write request (1 address byte, then DATA_LENGTH data bytes,
//   MSB first), issues a single-cycle write strobe, then returns a one-byte
//   ack packet on the TX stream.
//
//   Ports:
//     ipClk        clock
//     reset        synchronous, active-high reset
//     bus          write_controller_if.slave (RX/TX streams, write port, error)
//     dbg_state_o  current FSM state (0 IDLE, 1 GET_DATA, 2 WRITE, 3 SEND_ACK)
//
//   Timing: last data byte accepted at edge N -> opWrEnable high for the
//   cycle after N -> ack Valid high from the edge after that.
// -----------------------------------------------------------------------------
module write_controller
    import write_controller_pkg::*;
#(
    parameter int         DATA_LENGTH = 4,
    parameter logic [7:0] WR_DEST     = 8'h01,
    parameter logic [7:0] ACK_SRC     = 8'h01
) (
    input  logic                   ipClk,
    input  logic                   reset,
    write_controller_if.slave      bus,
    output logic [1:0]             dbg_state_o
);

    localparam int         W        = 8 * DATA_LENGTH;
    localparam int         CW       = $clog2(DATA_LENGTH + 1);
    localparam logic [7:0] LEN_BYTE = 8'(DATA_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        WRITE    = 2'd2,
        SEND_ACK = 2'd3
    } state_t;

    state_t         state_q;
    logic [7:0]     addr_q;       // address of the packet in progress
    logic [7:0]     src_q;        // requester, becomes the ack destination
    logic [CW-1:0]  cnt_q;        // data bytes still expected
    logic [W-1:0]   shift_q;      // data bytes received so far
    logic [7:0]     wr_addr_q;
    logic [W-1:0]   wr_data_q;
    logic           wr_en_q;
    logic           error_q;
    UART_PACKET     tx_q;

    UART_PACKET     rx;
    logic           hdr_ok;
    logic           last_byte;
    logic [W+7:0]   shift_ext;
    logic [W-1:0]   shift_d;

    assign rx        = bus.ipRxStream;
    assign hdr_ok    = (rx.Destination == WR_DEST) && (rx.Length == LEN_BYTE);
    assign last_byte = (cnt_q == CW'(1));

    // New byte enters at the LSB, so the first data byte ends at the MSB.
    assign shift_ext = {shift_q, rx.Data};
    assign shift_d   = shift_ext[W-1:0];

    always_ff @(posedge ipClk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            src_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            error_q   <= 1'b0;
            tx_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            error_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // SoP packets for other controllers are silently ignored.
                    if (rx.Valid && rx.SoP && hdr_ok) begin
                        addr_q  <= rx.Data;
                        src_q   <= rx.Source;
                        cnt_q   <= CW'(DATA_LENGTH);
                        state_q <= GET_DATA;
                    end
                end

                GET_DATA: begin
                    if (rx.Valid) begin
                        if (rx.SoP) begin
                            // Truncated packet: flag it, then treat this
                            // byte as a fresh header.
                            error_q <= 1'b1;
                            if (hdr_ok) begin
                                addr_q  <= rx.Data;
                                src_q   <= rx.Source;
                                cnt_q   <= CW'(DATA_LENGTH);
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q - CW'(1);
                            if (last_byte) begin
                                if (rx.EoP) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= shift_d;
                                    state_q   <= WRITE;
                                end else begin
                                    error_q <= 1'b1;
                                    state_q <= IDLE;
                                end
                            end else if (rx.EoP) begin
                                error_q <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                end

                WRITE: begin
                    // Strobe is high during this state; RX bytes are dropped.
                    tx_q <= '{Source:      ACK_SRC,
                              Destination: src_q,
                              Length:      8'd1,
                              Data:        addr_q,
                              SoP:         1'b1,
                              EoP:         1'b1,
                              Valid:       1'b1};
                    state_q <= SEND_ACK;
                end

                SEND_ACK: begin
                    if (bus.ipTxReady) begin
                        tx_q    <= '0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.opTxStream  = tx_q;
    assign bus.opWrAddress = wr_addr_q;
    assign bus.opWrData    = wr_data_q;
    assign bus.opWrEnable  = wr_en_q;
    assign bus.opError     = error_q;
    assign dbg_state_o     = state_q;

endmodule
